// File: rtl/adc_capture_ctrl.sv
// Multi-channel ADC capture: decimation, channel mask, serialiser, FIFO.
// Words are {ch_idx[1:0], sample[13:0]}, read through a registered pop port.
module adc_capture_ctrl #(
  parameter int PRECISION  = 10,
  parameter int CHANNELS   = 2,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          adc_valid,
  input  logic [CHANNELS*PRECISION-1:0] adc_code_in,
  input  logic                          arm,
  input  logic                          stop,
  input  logic                          clear,
  input  logic                          mode,
  input  logic [15:0]                   capture_len,
  input  logic [7:0]                    decim,
  input  logic [CHANNELS-1:0]           ch_mask,
  input  logic                          rd_en,
  output logic [15:0]                   rd_data,
  output logic                          rd_valid,
  output logic                          empty,
  output logic                          full,
  output logic [DEPTH_LOG2:0]           word_count,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   overflow_count
);

  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic                          mode_q;
  logic [15:0]                   len_q;
  logic [7:0]                    decim_q;
  logic [CHANNELS-1:0]           mask_q;
  logic [7:0]                    dcnt;
  logic [15:0]                   fcnt;
  logic                          stop_q;
  logic [CHANNELS*PRECISION-1:0] frame_q;
  logic [CHANNELS-1:0]           pend;
  logic [CHANNELS-1:0]           pend_nx;
  logic [AW:0]                   wptr;
  logic [AW:0]                   rptr;
  logic [15:0]                   mem [DEPTH];

  logic        found;
  logic [1:0]  ser_ch;
  logic [13:0] ser_smp;
  logic [15:0] ser_word;
  logic        ser_wr;
  logic        halt;
  logic        capturing;
  logic        strobe;
  logic        hit;
  logic        load;
  logic        fdrop;
  logic        rd_go;
  logic        wr_go;
  logic        wdrop;
  logic [16:0] ovf_sum;

  // Lowest pending channel goes out first.
  always_comb begin
    found   = 1'b0;
    ser_ch  = '0;
    ser_smp = '0;
    pend_nx = pend;
    for (int k = 0; k < CHANNELS; k++) begin
      if (pend[k] && !found) begin
        found      = 1'b1;
        ser_ch     = 2'(k);
        ser_smp    = 14'(frame_q[k*PRECISION +: PRECISION]);
        pend_nx[k] = 1'b0;
      end
    end
  end

  assign ser_wr   = |pend;
  assign ser_word = {ser_ch, ser_smp};

  assign halt      = stop || stop_q;
  assign capturing = (state == CAPTURE) && !halt &&
                     (!mode_q || fcnt != len_q);
  assign strobe    = capturing && adc_valid;
  assign hit       = strobe && (dcnt == decim_q);
  // A frame fits if the serialiser emits its last word this cycle.
  assign load      = hit && (pend_nx == '0);
  assign fdrop     = hit && (pend_nx != '0);

  assign word_count = wptr - rptr;
  assign empty      = (word_count == '0);
  assign full       = word_count[AW];

  assign rd_go = rd_en && !empty && !clear;
  assign wr_go = ser_wr && !clear && (!full || rd_go);
  assign wdrop = ser_wr && !clear && full && !rd_go;

  assign ovf_sum = {1'b0, overflow_count} + 17'(fdrop) + 17'(wdrop);

  assign busy = (state == CAPTURE);
  assign done = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (arm) state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (halt) begin
          if (!ser_wr) state_nx = IDLE;
        end else if (mode_q && fcnt == len_q && !ser_wr) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mode_q         <= 1'b0;
      len_q          <= '0;
      decim_q        <= '0;
      mask_q         <= '0;
      dcnt           <= '0;
      fcnt           <= '0;
      stop_q         <= 1'b0;
      frame_q        <= '0;
      pend           <= '0;
      wptr           <= '0;
      rptr           <= '0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      overflow_count <= '0;
    end else begin
      state <= state_nx;
      if (state != CAPTURE && arm) begin
        mode_q  <= mode;
        len_q   <= capture_len;
        decim_q <= decim;
        mask_q  <= ch_mask;
        dcnt    <= '0;
        fcnt    <= '0;
        stop_q  <= 1'b0;
      end else if (state == CAPTURE) begin
        if (stop) stop_q <= 1'b1;
        if (strobe) begin
          dcnt <= hit ? 8'd0 : dcnt + 8'd1;
          if (hit) fcnt <= fcnt + 16'd1;
        end
      end
      pend <= load ? mask_q : pend_nx;
      if (load) frame_q <= adc_code_in;
      if (clear) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_go) wptr <= wptr + 1'b1;
        if (rd_go) rptr <= rptr + 1'b1;
      end
      rd_valid <= rd_go;
      if (rd_go) rd_data <= mem[rptr[AW-1:0]];
      if (clear) overflow_count <= '0;
      else overflow_count <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem[wptr[AW-1:0]] <= ser_word;
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_adc_capture_ctrl;

  localparam int P     = 10;
  localparam int CH    = 2;
  localparam int DL    = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          adc_valid;
  logic [CH*P-1:0] adc_code_in;
  logic          arm;
  logic          stop;
  logic          clear;
  logic          mode;
  logic [15:0]   capture_len;
  logic [7:0]    decim;
  logic [CH-1:0] ch_mask;
  logic          rd_en;
  logic [15:0]   rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [DL:0]   word_count;
  logic          busy;
  logic          done;
  logic [15:0]   overflow_count;

  adc_capture_ctrl #(
    .PRECISION (P),
    .CHANNELS  (CH),
    .DEPTH_LOG2(DL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .adc_valid     (adc_valid),
    .adc_code_in   (adc_code_in),
    .arm           (arm),
    .stop          (stop),
    .clear         (clear),
    .mode          (mode),
    .capture_len   (capture_len),
    .decim         (decim),
    .ch_mask       (ch_mask),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .empty         (empty),
    .full          (full),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .overflow_count(overflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // reference model: 0 idle, 1 capture, 2 done
  int          m_st;
  int          m_dc;
  int          m_fc;
  bit          m_stopping;
  bit          m_mode;
  int          m_len;
  int          m_decim;
  logic [CH-1:0] m_mask;
  logic [15:0] m_pend[$];
  logic [15:0] m_fifo[$];
  int          m_ovf;
  logic        m_rv;
  logic [15:0] m_rd;
  logic [15:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit   sw;
    logic [15:0] w;
    bit   halt;
    bit   acc;
    bit   rg;
    int   ovinc;
    int   nst;
    if (rst) begin
      m_st = 0; m_dc = 0; m_fc = 0; m_stopping = 0;
      m_pend.delete(); m_fifo.delete();
      m_ovf = 0; m_rv = 0; m_rd = '0;
      return;
    end
    sw    = m_pend.size() > 0;
    w     = sw ? m_pend[0] : 16'h0;
    halt  = m_stopping || stop;
    acc   = 0;
    ovinc = 0;
    if (m_st == 1 && !halt && adc_valid && (!m_mode || m_fc < m_len)) begin
      if (m_dc == m_decim) begin
        acc = 1; m_dc = 0;
      end else m_dc++;
    end
    nst = m_st;
    if (m_st != 1 && arm) nst = 1;
    else if (m_st == 1) begin
      if (halt) begin
        if (!sw) nst = 0;
      end else if (m_mode && m_fc == m_len && !sw) nst = 2;
    end
    if (sw) void'(m_pend.pop_front());
    if (acc) begin
      m_fc++;
      if (m_pend.size() == 0) begin
        for (int k = 0; k < CH; k++)
          if (m_mask[k])
            m_pend.push_back({2'(k), 14'(adc_code_in[k*P +: P])});
      end else ovinc++;
    end
    rg = rd_en && m_fifo.size() > 0 && !clear;
    if (clear) begin
      m_fifo.delete();
      m_ovf = 0;
      m_rv  = 0;
    end else begin
      m_rv = rg;
      if (rg) m_rd = m_fifo.pop_front();
      if (sw) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
        else ovinc++;
      end
      m_ovf = m_ovf + ovinc;
      if (m_ovf > 16'hFFFF) m_ovf = 16'hFFFF;
    end
    if (m_st == 1 && stop) m_stopping = 1;
    if (m_st != 1 && arm) begin
      m_mode = mode; m_len = capture_len; m_decim = decim;
      m_mask = ch_mask; m_dc = 0; m_fc = 0; m_stopping = 0;
    end
    m_st = nst;
  endtask

  task automatic check_all();
    chk("rd_valid", rd_valid, m_rv);
    chk("rd_data", rd_data, m_rd);
    chk("empty", empty, m_fifo.size() == 0);
    chk("full", full, m_fifo.size() == DEPTH);
    chk("word_count", word_count, m_fifo.size());
    chk("busy", busy, m_st == 1);
    chk("done", done, m_st == 2);
    chk("overflow_count", overflow_count, m_ovf);
    if (rd_valid) got.push_back(rd_data);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_arm();
    arm = 1'b1; cyc(); arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic strobe(input logic [CH*P-1:0] code);
    adc_code_in = code; adc_valid = 1'b1; cyc(); adc_valid = 1'b0;
  endtask

  logic [CH*P-1:0] codes[9];

  initial begin
    rst = 1'b1; adc_valid = 0; adc_code_in = '0; arm = 0; stop = 0;
    clear = 0; mode = 0; capture_len = 0; decim = 0; ch_mask = 0;
    rd_en = 0;
    run(2);
    rst = 1'b0;
    chk("reset_empty", empty, 1);
    chk("reset_busy", busy, 0);
    chk("reset_count", word_count, 0);

    // one-shot, 3 frames, both channels, reader draining
    mode = 1; capture_len = 3; decim = 0; ch_mask = 2'b11; rd_en = 1;
    got.delete();
    pulse_arm();
    for (int f = 1; f <= 3; f++) begin
      strobe({10'(10'h200 + f), 10'(f)});
      run(3);
    end
    run(4);
    chk("s1_nwords", got.size(), 6);
    if (got.size() == 6) begin
      chk("s1_w0", got[0], 16'h0001);
      chk("s1_w1", got[1], 16'h4201);
      chk("s1_w2", got[2], 16'h0002);
      chk("s1_w3", got[3], 16'h4202);
      chk("s1_w5", got[5], 16'h4203);
    end
    chk("s1_done", done, 1);
    chk("s1_busy", busy, 0);
    chk("s1_ovf", overflow_count, 0);

    // continuous, decim=2: frames 3, 6, 9 kept
    mode = 0; decim = 2;
    got.delete();
    pulse_arm();
    for (int f = 0; f < 9; f++) begin
      codes[f] = 20'($urandom);
      strobe(codes[f]);
      run(2);
    end
    pulse_stop();
    run(4);
    chk("s2_nwords", got.size(), 6);
    if (got.size() == 6)
      for (int j = 0; j < 3; j++) begin
        chk("s2_ch0", got[2*j], {6'd0, codes[3*j+2][9:0]});
        chk("s2_ch1", got[2*j+1], {6'h10, codes[3*j+2][19:10]});
      end
    chk("s2_idle", busy, 0);

    // strobe every cycle: alternate frames dropped
    decim = 0;
    pulse_clear();
    pulse_arm();
    adc_valid = 1;
    for (int f = 0; f < 8; f++) begin
      adc_code_in = 20'($urandom);
      cyc();
    end
    adc_valid = 0;
    chk("s3_ovf", overflow_count, 4);
    pulse_stop();
    run(4);

    // tiny FIFO overflow, no reads
    rd_en = 0;
    pulse_clear();
    pulse_arm();
    for (int f = 0; f < 3; f++) begin
      codes[f] = 20'($urandom);
      strobe(codes[f]);
      run(2);
    end
    pulse_stop();
    run(2);
    chk("s4_full", full, 1);
    chk("s4_count", word_count, 4);
    chk("s4_ovf", overflow_count, 2);
    rd_en = 1; cyc(); rd_en = 0;
    chk("s4_rv", rd_valid, 1);
    chk("s4_rd", rd_data, {6'd0, codes[0][9:0]});
    chk("s4_count3", word_count, 3);

    // read and write in one cycle while full
    pulse_arm();
    strobe(20'($urandom));
    cyc();
    rd_en = 1; cyc(); rd_en = 0;
    chk("s5_count", word_count, 4);
    chk("s5_ovf", overflow_count, 2);
    pulse_stop();
    run(2);
    pulse_clear();
    chk("s5_empty", empty, 1);
    chk("s5_ovf0", overflow_count, 0);
    rd_en = 1; run(2); rd_en = 0;
    chk("s5_rv", rd_valid, 0);

    // reset mid-capture
    pulse_arm();
    strobe(20'($urandom));
    run(3);
    rst = 1; cyc(); rst = 0;
    chk("s6_busy", busy, 0);
    chk("s6_empty", empty, 1);
    chk("s6_rv", rd_valid, 0);
    chk("s6_rd", rd_data, 0);
    ch_mask = 2'b01; rd_en = 1;
    pulse_arm();
    strobe(20'h00055);
    run(3);
    chk("s6_busy2", busy, 1);
    pulse_stop();
    run(2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      mode        = 1'($urandom_range(0, 1));
      capture_len = 16'($urandom_range(0, 5));
      decim       = 8'($urandom_range(0, 3));
      ch_mask     = 2'($urandom_range(0, 3));
      arm         = $urandom_range(0, 19) == 0;
      stop        = $urandom_range(0, 29) == 0;
      clear       = $urandom_range(0, 49) == 0;
      adc_valid   = $urandom_range(0, 9) < 4;
      rd_en       = 1'($urandom_range(0, 1));
      adc_code_in = 20'($urandom);
      cyc();
    end
    arm = 0; stop = 0; clear = 0; adc_valid = 0; rd_en = 0;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Parametrised multi-channel ADC capture engine that succeeds the single-channel, always-writing FIFO path. It accepts frames of CHANNELS parallel samples and applies decimation and a channel mask. It serialises enabled channels into channel-tagged 16-bit words in an internal FIFO, read by the host pipe-out logic. Supports continuous and one-shot (fixed frame count) modes and counts dropped data. It sits between the ADC input synchroniser and the okPipeOut/okWireOut endpoints, all in one clock domain.

Parameters:
PRECISION, 10, ADC code width per channel; legal 1..14
CHANNELS, 2, parallel ADC channels per frame; legal 1..4
DEPTH_LOG2, 10, FIFO depth = 2**DEPTH_LOG2 words

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
adc_valid  input  1  one-cycle strobe: adc_code_in holds a new frame
adc_code_in  input  CHANNELS*PRECISION  frame; channel k at bits [k*PRECISION +: PRECISION]
arm  input  1  start capture (pulse); ignored while busy
stop  input  1  end continuous capture (pulse)
clear  input  1  flush FIFO and zero overflow_count (pulse)
mode  input  1  0 = continuous, 1 = one-shot
capture_len  input  16  frames to accept in one-shot mode
decim  input  8  accept one frame out of every decim+1 strobes
ch_mask  input  CHANNELS  per-channel write enable
rd_en  input  1  host read request (pipe-out ep_read)
rd_data  output  16  {ch_idx[1:0], zero-extended sample[13:0]}
rd_valid  output  1  rd_data valid this cycle
empty  output  1  FIFO empty
full  output  1  FIFO full
word_count  output  DEPTH_LOG2+1  words in FIFO
busy  output  1  state is CAPTURE
done  output  1  state is DONE
overflow_count  output  16  dropped words/frames, saturating

Behaviour:
- Reset values: rd_data=0, rd_valid=0, empty=1, full=0, word_count=0, busy=0, done=0, overflow_count=0; state IDLE; FIFO pointers, decimation counter, frame counter and serialiser all cleared. Reset mid-capture aborts immediately. Buffered data is lost.
- States: IDLE, CAPTURE, DONE.
  - IDLE/DONE + arm -> CAPTURE. mode, capture_len, decim and ch_mask are latched on that cycle. Decimation counter and frame counter are zeroed.
  - CAPTURE + one-shot: after capture_len frames are accepted and the serialiser is idle -> DONE. capture_len=0 goes to DONE on the cycle after arm.
  - CAPTURE + stop (either mode) -> stop accepting frames; go to IDLE once the serialiser is idle.
  - arm while in CAPTURE is ignored.
- Decimation: each adc_valid in CAPTURE increments the decimation counter. A frame is accepted when the counter equals decim; the counter then wraps to 0. With decim=0 every strobe is accepted.
- Serialiser:
  - An accepted frame is latched. On the following cycles it writes one word per cycle for each set ch_mask bit, in ascending channel order. A mask with m set bits takes m cycles.
  - ch_mask=0: the frame counts toward capture_len but writes nothing.
  - If a frame is accepted while the serialiser is still busy, that frame is dropped whole and overflow_count increments by 1.
- Word format: bits[15:14] = channel index; bits[13:0] = sample, zero-extended from PRECISION.
- FIFO:
  - A write while full drops that word and increments overflow_count by 1.
  - overflow_count saturates at 16'hFFFF.
  - full = (word_count == 2**DEPTH_LOG2).
- Read path:
  - rd_en with !empty pops one word. rd_data and rd_valid are registered, 1-cycle latency.
  - rd_en while empty is ignored: rd_valid=0, rd_data holds its last value.
- Simultaneous read and write in one cycle: both occur and word_count is unchanged. A write while full in the same cycle as a read succeeds, because the read frees the slot.
- clear: empties FIFO (word_count=0, empty=1) and zeroes overflow_count. It does not change state. A write in the same cycle as clear is discarded. clear takes priority over rd_en.
- Pointer wrap: pointers are DEPTH_LOG2+1 bits. Wrap-around is transparent to ordering.

Test Plan:
- Reset, CHANNELS=2, ch_mask=2'b11, mode=1, capture_len=3, decim=0, arm, adc_valid every 4 cycles with ch0=10'h001.., ch1=10'h201.. -> 6 words: 16'h0001, 16'h4201, 16'h0002, 16'h4202, ...; done=1, busy=0, overflow_count=0.
- decim=2, mode=0, 9 strobes, stop -> exactly frames 3, 6, 9 written (6 words); state IDLE after serialiser drains.
- adc_valid every cycle with ch_mask=2'b11, decim=0 -> alternate frames dropped; overflow_count increments once per dropped frame.
- DEPTH_LOG2=2, continuous, no reads, 6 words produced -> full=1, word_count=4, overflow_count=2. One rd_en -> rd_valid next cycle with the first word, word_count=3.
- Fill, then assert rd_en and a serialiser write in the same cycle -> word_count unchanged. clear -> empty=1, overflow_count=0. rd_en while empty -> rd_valid stays 0.
- rst asserted mid-capture with FIFO non-empty -> next cycle all outputs at reset values. A subsequent arm restarts cleanly.
